commit_stage: RTL

In-order retirement stage sitting directly downstream of the reorder buffer. Each cycle it inspects the ROB head entry and pulses `commit_ren` when the entry may retire. On retirement it maintains the retirement RAT (RRAT) and returns the superseded physical register to the free list. Stores are sequenced through a two-state handshake with the store queue before they retire.

---
 rtl/commit_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/commit_stage.sv
// commit_stage
// In-order retirement stage fed by the reorder buffer head entry.
// Retires one eligible non-store head per cycle (commit_ren combinational),
// maintains the retirement RAT, returns superseded physical registers to the
// free list, and sequences stores through a request/ack handshake with the
// store queue before letting them retire.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rob_empty       ROB holds no entries
//   head_done       head entry completed
//   head_regf_we    head writes an architectural register
//   head_rd_arch    head destination architectural register
//   head_pd         physical register allocated to the head destination
//   head_is_store   head entry is a store
//   commit_ren      head retires this cycle
//   st_commit_req   one-cycle request to the store queue
//   st_commit_ack   store queue performed the head store
//   free_push       return free_preg to the free list
//   free_preg       physical register being freed (0 when free_push = 0)
//   rrat_map        flattened RRAT, entry i at [i*PREG_W +: PREG_W]
//   instret         retired-instruction count (wraps mod 2^64)
module commit_stage #(
  parameter int PREG_COUNT = 64,
  parameter int PREG_W     = $clog2(PREG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rob_empty,
  input  logic                   head_done,
  input  logic                   head_regf_we,
  input  logic [4:0]             head_rd_arch,
  input  logic [PREG_W-1:0]      head_pd,
  input  logic                   head_is_store,
  output logic                   commit_ren,
  output logic                   st_commit_req,
  input  logic                   st_commit_ack,
  output logic                   free_push,
  output logic [PREG_W-1:0]      free_preg,
  output logic [32*PREG_W-1:0]   rrat_map,
  output logic [63:0]            instret
);

  typedef enum logic {
    IDLE    = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [PREG_W-1:0]   rrat [32];
  logic                eligible;
  logic                rrat_we;

  assign eligible = !rob_empty && head_done;

  // Next-state and pulse outputs. Everything is forced quiet while rst is
  // high so an ack that lands in the reset cycle cannot produce a commit.
  always_comb begin
    state_nxt     = state;
    commit_ren    = 1'b0;
    st_commit_req = 1'b0;
    free_push     = 1'b0;
    free_preg     = '0;
    rrat_we       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (eligible) begin
            if (head_is_store) begin
              st_commit_req = 1'b1;
              state_nxt     = ST_WAIT;
            end else begin
              commit_ren = 1'b1;
              // x0 is hardwired: never remapped, never frees anything.
              if (head_regf_we && head_rd_arch != 5'd0) begin
                free_push = 1'b1;
                free_preg = rrat[head_rd_arch];
                rrat_we   = 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          // Stores retire without touching the RRAT, whatever regf_we says.
          if (st_commit_ack) begin
            commit_ren = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, RRAT and retirement counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instret <= '0;
      for (int i = 0; i < 32; i++) begin
        rrat[i] <= PREG_W'(i);
      end
    end else begin
      state <= state_nxt;
      if (commit_ren) begin
        instret <= instret + 64'd1;
      end
      if (rrat_we) begin
        rrat[head_rd_arch] <= head_pd;
      end
    end
  end

  always_comb begin
    rrat_map = '0;
    for (int i = 0; i < 32; i++) begin
      rrat_map[i*PREG_W +: PREG_W] = rrat[i];
    end
  end

endmodule
